// File: rtl/urng_lcg_multi.sv
// urng_lcg_multi: NCH lock-step 64-bit LCG streams (mod 2^64) with optional
// PCG XSH-RR output permutation, valid/ready output and a beat counter.
module urng_lcg_multi #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned OUT_W  = 32,
  parameter logic [63:0] A      = 64'h5851F42D4C957F2D,
  parameter logic [63:0] C      = 64'h14057B7EF767814F,
  parameter logic [63:0] SEED   = 64'h123456789ABCDEF0,
  parameter bit          TEMPER = 1'b1,
  // internal beat-counter width; sample_cnt is this counter zero-extended
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [63:0]          seed_in,
  input  logic                 rand_ready,
  output logic [NCH*OUT_W-1:0] rand_out,
  output logic                 rand_valid,
  output logic [31:0]          sample_cnt
);

  logic [63:0]      s_p0 [NCH];
  logic [CNT_W-1:0] cnt_p0;
  logic             adv;

  // Output permutation of one channel state. XSH-RR: the xorshift-then-shift
  // term reduces to s[58:27] ^ s[63:45]; rotate amount comes from the top 5 bits.
  function automatic logic [OUT_W-1:0] perm(input logic [63:0] st);
    logic [31:0] x;
    logic [31:0] p;
    logic [4:0]  r;
    logic [4:0]  rl;
    x  = st[58:27] ^ {13'd0, st[63:45]};
    r  = st[63:59];
    rl = 5'd0 - r;
    p  = (x >> r) | (x << rl);
    if (TEMPER) perm = OUT_W'(p >> (32 - OUT_W));
    else        perm = OUT_W'(st >> (64 - OUT_W));
  endfunction

  // A new beat is produced when enabled and the output slot is free or being drained
  assign adv = en && (!rand_valid || rand_ready);

  // ---- stage p0: LCG state; reseed to seed+i, step only when a beat is produced
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rstn)          s_p0[i] <= SEED + 64'(i);
      else if (seed_load) s_p0[i] <= seed_in + 64'(i);
      else if (adv)       s_p0[i] <= A * s_p0[i] + C + 64'(2 * i);
    end
  end

  // ---- stage p1: registered output beat, permuted from the pre-advance state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rand_out <= '0;
    end else if (!seed_load && adv) begin
      for (int i = 0; i < NCH; i++) begin
        rand_out[i*OUT_W +: OUT_W] <= perm(s_p0[i]);
      end
    end
  end

  // Handshake valid and beat counter; seed_load discards any pending beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rand_valid <= 1'b0;
      cnt_p0     <= '0;
    end else if (seed_load) begin
      rand_valid <= 1'b0;
      cnt_p0     <= '0;
    end else if (adv) begin
      rand_valid <= 1'b1;
      cnt_p0     <= cnt_p0 + CNT_W'(1);
    end else if (rand_valid && rand_ready) begin
      rand_valid <= 1'b0;
    end
  end

  assign sample_cnt = 32'(cnt_p0);

endmodule

// File: tb/tb_urng_lcg_multi.sv
// Scoreboard bench for urng_lcg_multi: two instances (raw NCH=2/OUT_W=32 and
// XSH-RR NCH=4/OUT_W=16 with a 3-bit counter) driven by the same stimulus.
module tb_urng_lcg_multi;

  localparam logic [63:0] A    = 64'h5851F42D4C957F2D;
  localparam logic [63:0] C    = 64'h14057B7EF767814F;
  localparam logic [63:0] SEED = 64'h123456789ABCDEF0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [63:0] seed_in = '0;
  logic        rand_ready = 1'b0;
  logic [63:0] out0;
  logic        vld0;
  logic [31:0] cnt0;
  logic [63:0] out1;
  logic        vld1;
  logic [31:0] cnt1;

  int n_vec = 0;
  int n_err = 0;

  urng_lcg_multi #(.NCH(2), .OUT_W(32), .TEMPER(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .rand_ready(rand_ready), .rand_out(out0), .rand_valid(vld0), .sample_cnt(cnt0));

  urng_lcg_multi #(.NCH(4), .OUT_W(16), .TEMPER(1'b1), .CNT_W(3)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .rand_ready(rand_ready), .rand_out(out1), .rand_valid(vld1), .sample_cnt(cnt1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] o0;
    logic [63:0] o1;
    logic [31:0] c0;
    logic [31:0] c1;
  } beat_t;

  beat_t       q[$];
  beat_t       mon_b;
  logic [63:0] m_s [4];
  logic        m_valid;
  logic [31:0] m_cnt;
  int          n_beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_step(input logic [63:0] s, input int i);
    return s * A + (C + 64'(2 * i));
  endfunction

  // Reference XSH-RR, rotating one bit at a time, top 16 bits kept
  function automatic logic [15:0] ref_pcg16(input logic [63:0] s);
    logic [31:0] p;
    int r;
    p = 32'((s >> 27) ^ (s >> 45));
    r = int'(s >> 59);
    for (int k = 0; k < r; k++) p = {p[0], p[31:1]};
    return p[31:16];
  endfunction

  task automatic model_reseed(input logic [63:0] sd);
    for (int i = 0; i < 4; i++) m_s[i] = sd + 64'(i);
    m_valid = 1'b0;
    m_cnt   = '0;
  endtask

  // Drive one cycle of inputs, update the model and push the expected beat
  task automatic step(input logic e, input logic r, input logic l, input logic [63:0] sd);
    beat_t b;
    en = e; rand_ready = r; seed_load = l; seed_in = sd;
    if (l) begin
      if (m_valid && !r && q.size() > 0) void'(q.pop_back());
      model_reseed(sd);
    end else if (e && (!m_valid || r)) begin
      b.o0 = {m_s[1][63:32], m_s[0][63:32]};
      b.o1 = {ref_pcg16(m_s[3]), ref_pcg16(m_s[2]), ref_pcg16(m_s[1]), ref_pcg16(m_s[0])};
      b.c0 = m_cnt + 32'd1;
      b.c1 = (m_cnt + 32'd1) & 32'd7;
      q.push_back(b);
      for (int i = 0; i < 4; i++) m_s[i] = ref_step(m_s[i], i);
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      n_beats++;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("valid0", 64'(vld0), 64'(m_valid));
    check("valid1", 64'(vld1), 64'(m_valid));
    if (m_valid && q.size() > 0) begin
      check("held_out0", out0, q[$].o0);
      check("held_out1", out1, q[$].o1);
      check("held_cnt0", 64'(cnt0), 64'(q[$].c0));
      check("held_cnt1", 64'(cnt1), 64'(q[$].c1));
    end
  endtask

  // Monitor: every transfer must match the oldest outstanding expected beat
  always @(negedge clk) begin
    if (rstn && vld0 && rand_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL xfer_unexpected: got beat %h with empty scoreboard", out0);
      end else begin
        mon_b = q.pop_front();
        check("xfer_out0", out0, mon_b.o0);
        check("xfer_out1", out1, mon_b.o1);
        check("xfer_cnt0", 64'(cnt0), 64'(mon_b.c0));
        check("xfer_cnt1", 64'(cnt1), 64'(mon_b.c1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_start;
    int guard;
    // Reset defaults
    rstn = 1'b0; en = 1'b1; rand_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid0", 64'(vld0), 64'd0);
    check("rst_out0", out0, 64'd0);
    check("rst_cnt0", 64'(cnt0), 64'd0);
    check("rst_valid1", 64'(vld1), 64'd0);
    check("rst_out1", out1, 64'd0);
    check("rst_cnt1", 64'(cnt1), 64'd0);
    model_reseed(SEED);
    rstn = 1'b1;

    step(1, 1, 0, 0);
    check("first_beat0", out0, 64'h12345678_12345678);
    check("first_cnt0", 64'(cnt0), 64'd1);
    repeat (4) step(1, 1, 0, 0);

    // Backpressure with en held high
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0);
      check("bp_cnt0", 64'(cnt0), 64'd5);
      check("bp_valid0", 64'(vld0), 64'd1);
    end
    repeat (3) step(1, 1, 0, 0);

    // Mid-stream reset restarts from SEED
    rstn = 1'b0;
    @(posedge clk); #1;
    q.delete();
    model_reseed(SEED);
    check("midrst_valid0", 64'(vld0), 64'd0);
    check("midrst_cnt0", 64'(cnt0), 64'd0);
    rstn = 1'b1;
    step(1, 1, 0, 0);
    check("midrst_beat0", out0, 64'h12345678_12345678);

    // Seed load 0 and the first LCG step
    step(1, 1, 1, 64'd0);
    check("load0_cnt0", 64'(cnt0), 64'd0);
    step(1, 1, 0, 0);
    check("load0_beat1_0", out0, 64'd0);
    check("load0_beat1_1", out1, 64'd0);
    check("load0_beat1_cnt", 64'(cnt0), 64'd1);
    step(1, 1, 0, 0);
    check("load0_beat2_0", out0, 64'h6C576FAC_14057B7E);

    // seed_load together with en and ready; seed_in + i wraps on channel 1
    step(1, 1, 1, 64'hFFFFFFFF_FFFFFFFF);
    check("simul_valid0", 64'(vld0), 64'd0);
    check("simul_cnt0", 64'(cnt0), 64'd0);
    step(1, 1, 0, 0);
    check("wrapseed_beat0", out0, 64'h00000000_FFFFFFFF);
    check("wrapseed_beat1", out1, 64'h0000_0000_0000_FFF0);

    // en=0 while a beat is being taken: valid drops
    step(0, 1, 0, 0);
    check("en0_drop_valid0", 64'(vld0), 64'd0);
    step(0, 0, 0, 0);

    // Pending beat discarded by seed_load under backpressure
    step(1, 1, 0, 0);
    step(1, 0, 1, 64'd0);
    step(1, 1, 0, 0);
    check("tmp_beat1_ch0", 64'(out1[15:0]), 64'd0);

    // Long run with random ready and occasional en drops
    n_start = n_beats;
    guard = 0;
    while ((n_beats - n_start) < 1000 && guard < 6000) begin
      step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 1)), 1'b0, 64'd0);
      guard++;
    end
    check("random_beats", 64'(n_beats - n_start), 64'd1000);

    // Drain the last beat
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("drain_queue", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
